// File: rtl/calc_op_seq_pkg.sv
// ---------------------------------------------------------------------------
// calc_op_seq_pkg
// Shared calculator definitions: operation encodings, sequencer FSM state
// encodings and the width of the WAIT timeout counter.
// No ports (package).
// ---------------------------------------------------------------------------
package calc_op_seq_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

endpackage : calc_op_seq_pkg

// File: rtl/calc_op_seq_op_decode_onehot.sv
// ---------------------------------------------------------------------------
// op_decode_onehot
// 2-to-4 one-hot decoder selecting the functional unit for an operation.
// Ports:
//   op     in  2  operation code (calc_op_seq_pkg::op_t)
//   en     in  1  decoder enable; all outputs zero when low
//   onehot out 4  one-hot unit select, bit i selects unit i
// ---------------------------------------------------------------------------
module op_decode_onehot
   import calc_op_seq_pkg::*;
(
   input  op_t        op,
   input  logic       en,
   output logic [3:0] onehot
);

   always_comb begin
      onehot = 4'b0000;
      if (en) begin
         onehot[op] = 1'b1;
      end
   end

endmodule : op_decode_onehot

// File: rtl/calc_op_seq.sv
// ---------------------------------------------------------------------------
// calc_op_seq
// Sequencer that launches one operation on one of four functional units,
// waits for that unit's completion pulse (bounded by TIMEOUT cycles), then
// holds the latched result until the consumer accepts it.
// Ports:
//   clk          in  1  clock, rising edge
//   rst          in  1  synchronous active-high reset
//   start        in  1  operation request, sampled in IDLE only
//   op           in  2  operation select, captured with start
//   unit_done    in  4  per-unit completion pulses
//   bus_in       in  8  merged (OR) unit result bus
//   unit_en      out 4  one-hot enable of the selected unit
//   unit_start   out 1  one-cycle launch pulse (ISSUE)
//   bus_rst      out 1  blanks the merging OR stage; low only in WAIT
//   result       out 8  latched result (8'h00 on timeout)
//   result_valid out 1  result available (HOLD)
//   result_ack   in  1  consumer accepts result
//   busy         out 1  high outside IDLE
//   err          out 1  timeout flag, valid with result_valid
//
// Result handshake: result/err are presented with result_valid=1 and stay
// stable until a cycle in which result_valid=1 and result_ack=1; that cycle
// completes the transfer and result_valid drops on the following edge.
// result_ack in any other cycle has no effect.
//
// Every output is either a register or decoded from the registered state and
// op_q, so no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module calc_op_seq
   import calc_op_seq_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] op,
   input  logic [3:0] unit_done,
   input  logic [7:0] bus_in,
   output logic [3:0] unit_en,
   output logic       unit_start,
   output logic       bus_rst,
   output logic [7:0] result,
   output logic       result_valid,
   input  logic       result_ack,
   output logic       busy,
   output logic       err
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t           state_q;
   state_t           state_d;
   op_t              op_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc;
   logic [7:0]       result_q;
   logic             err_q;
   logic             sel_done;
   logic             tmo_hit;
   logic             dec_en;

   // Only the selected unit's done pulse counts; others are ignored.
   assign sel_done = unit_done[op_q];

   // cnt_q holds the number of WAIT cycles already completed, so the current
   // WAIT cycle is number cnt_q+1. Abort when that reaches TIMEOUT, giving
   // exactly TIMEOUT WAIT cycles before HOLD.
   assign cnt_inc = cnt_q + 1'b1;
   assign tmo_hit = (cnt_inc == TIMEOUT_C);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (sel_done || tmo_hit) state_d = ST_HOLD;
         ST_HOLD:  if (result_ack) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath registers: captured op, WAIT counter, result and error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q     <= OP_ADD;
         cnt_q    <= '0;
         result_q <= 8'h00;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) op_q <= op_t'(op);
            end
            ST_ISSUE: begin
               cnt_q <= '0;
            end
            ST_WAIT: begin
               cnt_q <= cnt_inc;
               // done has priority over a coincident timeout
               if (sel_done) begin
                  result_q <= bus_in;
                  err_q    <= 1'b0;
               end else if (tmo_hit) begin
                  result_q <= 8'h00;
                  err_q    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign dec_en = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

   op_decode_onehot u_dec (
      .op     (op_q),
      .en     (dec_en),
      .onehot (unit_en)
   );

   // Output decode from registered state
   always_comb begin
      unit_start   = 1'b0;
      bus_rst      = 1'b1;
      result_valid = 1'b0;
      busy         = 1'b1;
      case (state_q)
         ST_IDLE:  busy         = 1'b0;
         ST_ISSUE: unit_start   = 1'b1;
         ST_WAIT:  bus_rst      = 1'b0;
         ST_HOLD:  result_valid = 1'b1;
         default:  ;
      endcase
   end

   assign result = result_q;
   assign err    = err_q;

endmodule : calc_op_seq

// File: tb/tb_calc_op_seq.sv
module tb_calc_op_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] op;
   logic [3:0] unit_done;
   logic [7:0] bus_in;
   logic [3:0] unit_en;
   logic       unit_start;
   logic       bus_rst;
   logic [7:0] result;
   logic       result_valid;
   logic       result_ack;
   logic       busy;
   logic       err;

   int n_vec;
   int n_err;
   int n_launch;
   int launch_base;

   calc_op_seq #(.TIMEOUT(15)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .op           (op),
      .unit_done    (unit_done),
      .bus_in       (bus_in),
      .unit_en      (unit_en),
      .unit_start   (unit_start),
      .bus_rst      (bus_rst),
      .result       (result),
      .result_valid (result_valid),
      .result_ack   (result_ack),
      .busy         (busy),
      .err          (err)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one clock; outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
      if (unit_start === 1'b1) n_launch++;
      check("unit_en_onehot0", {31'd0, $onehot0(unit_en)}, 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_unit_en"}, {28'd0, unit_en}, 32'h0);
      check({tag, "_unit_start"}, {31'd0, unit_start}, 32'h0);
      check({tag, "_bus_rst"}, {31'd0, bus_rst}, 32'h1);
      check({tag, "_result"}, {24'd0, result}, 32'h0);
      check({tag, "_result_valid"}, {31'd0, result_valid}, 32'h0);
      check({tag, "_err"}, {31'd0, err}, 32'h0);
      check({tag, "_busy"}, {31'd0, busy}, 32'h0);
   endtask

   initial begin
      n_vec = 0; n_err = 0; n_launch = 0;
      rst = 1'b1; start = 1'b0; op = 2'd0; unit_done = 4'd0;
      bus_in = 8'h00; result_ack = 1'b0;

      // reset
      step(); step();
      rst = 1'b0;
      check_reset_vals("reset");

      // mul, done two cycles after start, bus 8'h2A
      op = 2'd2; start = 1'b1;
      step();
      start = 1'b0;
      check("mul_issue_en", {28'd0, unit_en}, 32'h4);
      check("mul_issue_start", {31'd0, unit_start}, 32'h1);
      check("mul_issue_busrst", {31'd0, bus_rst}, 32'h1);
      check("mul_issue_busy", {31'd0, busy}, 32'h1);
      step();
      check("mul_wait_en", {28'd0, unit_en}, 32'h4);
      check("mul_wait_start", {31'd0, unit_start}, 32'h0);
      check("mul_wait_busrst", {31'd0, bus_rst}, 32'h0);
      unit_done = 4'b0100; bus_in = 8'h2A;
      step();
      unit_done = 4'b0000; bus_in = 8'h00;
      check("mul_hold_valid", {31'd0, result_valid}, 32'h1);
      check("mul_hold_result", {24'd0, result}, 32'h2A);
      check("mul_hold_err", {31'd0, err}, 32'h0);
      check("mul_hold_en", {28'd0, unit_en}, 32'h0);
      check("mul_hold_busrst", {31'd0, bus_rst}, 32'h1);
      step();
      check("mul_hold2_valid", {31'd0, result_valid}, 32'h1);
      check("mul_hold2_result", {24'd0, result}, 32'h2A);
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      check("mul_ack_valid", {31'd0, result_valid}, 32'h0);
      check("mul_ack_busy", {31'd0, busy}, 32'h0);

      // div, no done: timeout after 15 WAIT cycles; ack during WAIT ignored
      op = 2'd3; start = 1'b1;
      step();
      start = 1'b0;
      check("div_issue_en", {28'd0, unit_en}, 32'h8);
      step();
      result_ack = 1'b1;
      repeat (14) step();
      result_ack = 1'b0;
      check("div_wait15_busrst", {31'd0, bus_rst}, 32'h0);
      check("div_wait15_valid", {31'd0, result_valid}, 32'h0);
      check("div_wait15_en", {28'd0, unit_en}, 32'h8);
      step();
      check("div_tmo_valid", {31'd0, result_valid}, 32'h1);
      check("div_tmo_result", {24'd0, result}, 32'h00);
      check("div_tmo_err", {31'd0, err}, 32'h1);
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      check("div_ack_busy", {31'd0, busy}, 32'h0);

      // mul, done in the same cycle as the timeout: done wins
      op = 2'd2; start = 1'b1;
      step();
      start = 1'b0;
      step();
      repeat (14) step();
      check("tie_wait15_busrst", {31'd0, bus_rst}, 32'h0);
      unit_done = 4'b0100; bus_in = 8'h5C;
      step();
      unit_done = 4'b0000; bus_in = 8'h00;
      check("tie_valid", {31'd0, result_valid}, 32'h1);
      check("tie_result", {24'd0, result}, 32'h5C);
      check("tie_err", {31'd0, err}, 32'h0);
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;

      // add: done from a different unit is ignored
      op = 2'd0; start = 1'b1;
      step();
      start = 1'b0;
      check("add_issue_en", {28'd0, unit_en}, 32'h1);
      step();
      unit_done = 4'b0010; bus_in = 8'h77;
      step();
      check("add_other_busrst", {31'd0, bus_rst}, 32'h0);
      check("add_other_valid", {31'd0, result_valid}, 32'h0);
      unit_done = 4'b0001; bus_in = 8'h13;
      step();
      unit_done = 4'b0000; bus_in = 8'h00;
      check("add_valid", {31'd0, result_valid}, 32'h1);
      check("add_result", {24'd0, result}, 32'h13);
      check("add_err", {31'd0, err}, 32'h0);
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;

      // reset in WAIT, coincident with a done pulse
      op = 2'd1; start = 1'b1;
      step();
      start = 1'b0;
      step();
      check("rstw_busrst", {31'd0, bus_rst}, 32'h0);
      rst = 1'b1; unit_done = 4'b0010; bus_in = 8'hEE;
      step();
      rst = 1'b0; unit_done = 4'b0000; bus_in = 8'h00;
      check_reset_vals("rst_wait");
      step();
      check_reset_vals("rst_wait_after");

      // start held high through the whole op and the ack: two ops total
      launch_base = n_launch;
      op = 2'd1; start = 1'b1;
      step();
      check("b2b_issue1", {31'd0, unit_start}, 32'h1);
      step();
      unit_done = 4'b0010; bus_in = 8'h0F;
      step();
      unit_done = 4'b0000; bus_in = 8'h00;
      check("b2b_result1", {24'd0, result}, 32'h0F);
      check("b2b_valid1", {31'd0, result_valid}, 32'h1);
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      check("b2b_idle_busy", {31'd0, busy}, 32'h0);
      step();
      start = 1'b0;
      check("b2b_issue2", {31'd0, unit_start}, 32'h1);
      check("b2b_issue2_en", {28'd0, unit_en}, 32'h2);
      step();
      unit_done = 4'b0010; bus_in = 8'hA5;
      step();
      unit_done = 4'b0000; bus_in = 8'h00;
      check("b2b_result2", {24'd0, result}, 32'hA5);
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      step(); step();
      check("b2b_idle_end", {31'd0, busy}, 32'h0);
      check("b2b_launches", n_launch - launch_base, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_calc_op_seq

// File: doc/calc_op_seq.md
CALC_OP_SEQ -- requirements
Module: calc_op_seq

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum number of WAIT cycles before the operation aborts; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  2  operation select: 0 add, 1 sub, 2 mul, 3 div; captured with start.
REQ-006 unit_done  input  4  per-unit completion pulses, bit i from functional unit i.
REQ-007 bus_in  input  8  merged result bus (OR of the four unit outputs).
REQ-008 unit_en  output  4  one-hot enable of the selected unit; all zero when no unit is selected.
REQ-009 unit_start  output  1  one-cycle launch pulse to the enabled unit.
REQ-010 bus_rst  output  1  drives the reset input of the merging OR stage; high blanks the bus.
REQ-011 result  output  8  latched operation result.
REQ-012 result_valid  output  1  result is available; held until it is accepted.
REQ-013 result_ack  input  1  consumer accepts the result.
REQ-014 busy  output  1  high in every state other than IDLE.
REQ-015 err  output  1  timeout flag, valid together with result_valid.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
REQ-017 IDLE: start=1 -> capture op, go to ISSUE the next cycle; start=0 -> stay in IDLE.
REQ-018 ISSUE (exactly 1 cycle): unit_en=onehot(op_q), unit_start=1, timeout counter cleared; next state WAIT.
REQ-019 WAIT: unit_en stays onehot(op_q); bus_rst=0; counter increments every cycle.
REQ-020 WAIT exit on unit_done[op_q]=1: latch bus_in into result, err=0, go to HOLD; done bits of other units are ignored.
REQ-021 WAIT exit on counter==TIMEOUT with no done: result=8'h00, err=1, go to HOLD.
REQ-022 If done and timeout occur in the same cycle, done wins: err=0 and bus_in is latched.
REQ-023 HOLD: unit_en=0, bus_rst=1, result_valid=1, result/err stable; result_ack=1 -> IDLE the next cycle.
REQ-024 bus_rst SHALL be 1 in IDLE, ISSUE and HOLD, and 0 only in WAIT.
REQ-025 Minimum latency: start at cycle N, done at N+2 -> result_valid first high at N+3.
REQ-026 start asserted outside IDLE SHALL be ignored; it is not queued.
REQ-027 result_ack asserted outside HOLD SHALL be ignored.
REQ-028 Back-to-back operation: start in the cycle after HOLD exits is accepted normally.
REQ-029 At most one unit_en bit SHALL ever be high in any cycle.

Reset
REQ-030 rst=1 forces IDLE, unit_en=0, unit_start=0, bus_rst=1, result=0, result_valid=0, err=0, busy=0, counter=0 at the next edge.
REQ-031 rst mid-operation (ISSUE, WAIT or HOLD) aborts the operation without producing a result; a pending result is discarded.
REQ-032 rst has priority over every other input in the same cycle.

Structure
REQ-033 The op encodings (ADD..DIV), the FSM state encodings and the counter width (4) SHALL live in the shared calculator package.
REQ-034 One sub-module, op_decode_onehot (2-to-4 one-hot decoder), SHALL produce unit_en from op_q and an enable.
REQ-035 All outputs SHALL be registered or decoded solely from registered state; there is no combinational path from an input to an output.

Verification
REQ-036 op=2, start, done[2] two cycles later, bus_in=8'h2A -> unit_en=4'b0100, result=8'h2A, err=0, result_valid held until ack.
REQ-037 op=3, no done -> after 15 WAIT cycles: result=8'h00, err=1, result_valid=1.
REQ-038 done[2] and timeout in the same cycle (op=2) -> err=0 and bus_in is latched.
REQ-039 op=0, done[1] pulse only -> the block stays in WAIT; done[0] then latches the result.
REQ-040 rst pulsed in WAIT -> IDLE, all outputs at reset values, no result_valid.
REQ-041 start held high through HOLD with ack -> exactly two operations in total, with a one-cycle IDLE between them.
